// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage branch/jump resolution, registered redirect/misalign pulses, bimodal BHT training and event counters
module branch_resolve_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] if_pc_i,
  output logic                  if_pred_taken_o,
  input  logic                  ex_valid_i,
  input  logic                  ex_stall_i,
  input  logic                  ex_is_branch_i,
  input  logic                  ex_is_jal_i,
  input  logic                  ex_is_jalr_i,
  input  logic [2:0]            ex_funct3_i,
  input  logic                  BrEQ_i,
  input  logic                  BrLT_i,
  input  logic                  BrLTU_i,
  input  logic [DATA_WIDTH-1:0] ex_pc_i,
  input  logic [DATA_WIDTH-1:0] ex_imm_i,
  input  logic [DATA_WIDTH-1:0] ex_rs1_i,
  input  logic                  ex_pred_taken_i,
  output logic                  redirect_valid_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  output logic                  misalign_o,
  output logic [DATA_WIDTH-1:0] misalign_addr_o,
  output logic [31:0]           branch_cnt_o,
  output logic [31:0]           mispredict_cnt_o
);
  localparam int IW = $clog2(BHT_ENTRIES);
  logic [BHT_ENTRIES-1:0][1:0] bht_q, bht_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                  misalign_q, misalign_d;
  logic [DATA_WIDTH-1:0] misalign_addr_q, misalign_addr_d;
  logic [31:0]           branch_cnt_q, branch_cnt_d;
  logic [31:0]           mispredict_cnt_q, mispredict_cnt_d;
  logic                  accept, legal, taken, br, jmp, mis, to_target;
  logic [DATA_WIDTH-1:0] target, fall;
  logic [IW-1:0]         ex_idx;
  logic [1:0]            cur;
  logic                  if_pc_unused;
  assign if_pc_unused = ^{if_pc_i[DATA_WIDTH-1:IW+2], if_pc_i[1:0]};
  assign if_pred_taken_o = bht_q[if_pc_i[IW+1:2]][1];
  always_comb begin
    accept    = ex_valid_i & ~ex_stall_i & ~redirect_valid_q;
    legal     = ex_funct3_i[2] | ~ex_funct3_i[1];
    taken     = (ex_funct3_i[2] ? (ex_funct3_i[1] ? BrLTU_i : BrLT_i) : BrEQ_i) ^ ex_funct3_i[0];
    br        = accept & ex_is_branch_i & legal;
    jmp       = accept & (ex_is_jal_i | ex_is_jalr_i);
    mis       = br & (taken != ex_pred_taken_i);
    target    = ex_is_jalr_i ? ((ex_rs1_i + ex_imm_i) & ~DATA_WIDTH'(1)) : ex_pc_i + ex_imm_i;
    fall      = ex_pc_i + DATA_WIDTH'(4);
    to_target = jmp | (mis & taken);
    ex_idx    = ex_pc_i[IW+1:2];
    cur       = bht_q[ex_idx];
    // A misaligned target turns the redirect into a misalign pulse instead
    redirect_valid_d = to_target ? ~target[1] : mis;
    misalign_d       = to_target & target[1];
    redirect_pc_d    = redirect_valid_d ? (to_target ? target : fall) : redirect_pc_q;
    misalign_addr_d  = misalign_d ? target : misalign_addr_q;
    branch_cnt_d     = br ? branch_cnt_q + 32'd1 : branch_cnt_q;
    mispredict_cnt_d = mis ? mispredict_cnt_q + 32'd1 : mispredict_cnt_q;
    bht_d = bht_q;
    if (br) bht_d[ex_idx] = taken ? (cur == 2'b11 ? cur : cur + 2'b01) : (cur == 2'b00 ? cur : cur - 2'b01);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bht_q            <= {BHT_ENTRIES{2'b01}};
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      misalign_q       <= 1'b0;
      misalign_addr_q  <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      bht_q            <= bht_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      misalign_q       <= misalign_d;
      misalign_addr_q  <= misalign_addr_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign misalign_o       = misalign_q;
  assign misalign_addr_o  = misalign_addr_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

EX-stage branch resolution and prediction-training block that sits directly downstream of the branch comparator. It consumes the comparator's BrEQ/BrLT/BrLTU flags together with the decoded control-transfer type, and decides the actual outcome of each branch and jump. It issues a registered one-cycle redirect/flush request to the front end and trains a bimodal 2-bit branch history table (BHT), whose prediction port is read by IF. It also keeps branch and mispredict event counters.

## Interface
- DATA_WIDTH, 32 (core_pkg): PC, operand and target width.
- BHT_ENTRIES, 64: number of 2-bit counters; power of two, ≥ 4.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_pc_i  in  DATA_WIDTH  fetch PC to predict for.
- if_pred_taken_o  out  1  combinational MSB of BHT[if_pc_i index].
- ex_valid_i  in  1  EX holds a valid instruction.
- ex_stall_i  in  1  EX is held this cycle; no resolution.
- ex_is_branch_i / ex_is_jal_i / ex_is_jalr_i  in  1 each  control-transfer type; at most one set.
- ex_funct3_i  in  3  branch condition code.
- BrEQ_i, BrLT_i, BrLTU_i  in  1 each  comparator flags for rs1 vs rs2.
- ex_pc_i, ex_imm_i, ex_rs1_i  in  DATA_WIDTH each  instruction PC, sign-extended immediate, rs1 value.
- ex_pred_taken_i  in  1  prediction carried down the pipe with this branch.
- redirect_valid_o  out  1  registered one-cycle redirect; also the flush for IF/ID/EX.
- redirect_pc_o  out  DATA_WIDTH  fetch restart address; valid when redirect_valid_o is high.
- misalign_o  out  1  registered one-cycle pulse: taken target has bit[1] set.
- misalign_addr_o  out  DATA_WIDTH  offending target.
- branch_cnt_o, mispredict_cnt_o  out  32 each  event counters.

## Operation
- Accept: accept = ex_valid_i & !ex_stall_i & !redirect_valid_o. A cycle with redirect_valid_o high squashes the EX instruction. That instruction is ignored: no BHT update and no counting.
- Condition (branch only), by funct3:
  - 000: EQ
  - 001: !EQ
  - 100: LT
  - 101: !LT
  - 110: LTU
  - 111: !LTU
  - 010/011: illegal. Treated as not taken, no BHT update, no counting, no redirect.
- Targets:
  - Branch and JAL: ex_pc_i + ex_imm_i.
  - JALR: (ex_rs1_i + ex_imm_i) & ~1.
  - All adds are modulo 2^DATA_WIDTH.
  - Fall-through: ex_pc_i + 4.
- Redirect decision on an accepted instruction:
  - JAL/JALR: always redirect to the target.
  - Legal branch, taken != ex_pred_taken_i: redirect to the target if taken, else to the fall-through.
  - Legal branch, taken == ex_pred_taken_i: no redirect.
- Misalignment: if a redirect would go to the target and target[1]=1:
  - misalign_o pulses and misalign_addr_o = target.
  - The redirect is suppressed.
  - A not-taken fall-through is never misaligned.
- BHT:
  - Index = pc[log2(BHT_ENTRIES)+1:2].
  - Each entry is a 2-bit saturating counter, reset to 2'b01 (weakly not taken) on every entry.
  - On an accepted legal branch: increment if taken (saturate at 11), else decrement (saturate at 00).
  - Jumps do not train the BHT.
- Counters:
  - branch_cnt_o +1 per accepted legal branch.
  - mispredict_cnt_o +1 per accepted legal branch with taken != ex_pred_taken_i, including misaligned ones.
  - Both wrap 0xFFFF_FFFF→0.

## Timing
- Reset (asynchronous, rst_n low):
  - redirect_valid_o=0, redirect_pc_o=0, misalign_o=0, misalign_addr_o=0.
  - Both counters 0.
  - All BHT entries 01.
- Reset takes effect immediately, mid-operation included; a pending redirect is dropped.
- Latency: an instruction resolved (accepted) in cycle N produces redirect_valid_o / misalign_o in cycle N+1, for exactly one cycle. Counters and BHT show the update from N+1.
- redirect_valid_o and misalign_o are never high in the same cycle.
- Back-to-back: if the instruction accepted at N redirects, the instruction in EX at N+1 is squashed. A redirect is therefore never followed by another in the next cycle.
- Stall: while ex_stall_i=1 there is no update and no pulse. Resolution happens once, in the first unstalled cycle.
- BHT read/write collision: if_pred_taken_o is a combinational read of the current array. When IF reads an index that EX writes in the same cycle, IF sees the pre-write value; the write is visible the next cycle.

## Test plan
- Reset, then if_pc_i over all indices → if_pred_taken_o=0 everywhere; all outputs 0.
- BEQ, pc=0x100, imm=0x40, BrEQ=1, pred=0 → next cycle redirect_valid_o=1, redirect_pc_o=0x140, mispredict_cnt=1, BHT[0x100 index]=10; the cycle after, redirect_valid_o=0.
- BGEU, BrLTU=1, pred=1, pc=0x200 → redirect to 0x204. Repeat not-taken 3× → counter saturates at 00 with no underflow.
- JALR, rs1=0x1003, imm=0x4 → redirect_pc_o=0x1006 → bit1 set → misalign_o=1, misalign_addr_o=0x1006, redirect_valid_o=0. JALR, rs1=0x1001, imm=0 → redirect to 0x1000.
- Redirecting branch at N, second mispredicting branch valid at N+1 → second one squashed: single redirect, branch_cnt_o increments once. Stall held 3 cycles → exactly one resolution.
- funct3=010 with valid branch → no redirect, counters and BHT unchanged. rst_n dropped in the cycle redirect_valid_o is high → outputs 0 immediately.
